// File: rtl/lsb_queue.sv
// In-order load/store queue between dispatch and memory: captures ops, snoops the
// result buses, issues strictly from the head, and holds stores until ROB commit.
module lsb_queue #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic                     iss_store,
  input  logic [1:0]               iss_size,
  input  logic                     iss_sext,
  input  logic [XLEN-1:0]          iss_imm,
  input  logic [XLEN-1:0]          iss_rs1_val,
  input  logic [XLEN-1:0]          iss_rs2_val,
  input  logic                     iss_rs1_rdy,
  input  logic                     iss_rs2_rdy,
  input  logic [TAG_W-1:0]         iss_tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
  input  logic                     cmt_valid,
  input  logic [TAG_W-1:0]         cmt_tag,
  input  logic                     flush,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [1:0]               mem_size,
  input  logic                     mem_ack,
  input  logic [XLEN-1:0]          mem_rdata,
  output logic                     wb_valid,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [XLEN-1:0]          wb_data,
  output logic                     empty,
  output logic [1:0]               fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

  typedef struct packed {
    logic             valid;
    logic             store;
    logic             sext;
    logic             committed;
    logic [1:0]       size;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic             rs1_rdy;
    logic             rs2_rdy;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           q [DEPTH];
  entry_t           hd;
  entry_t           new_e;
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, ccount, ccount_n;
  state_t           state, state_n;
  logic [TAG_W-1:0] req_tag;
  logic             req_sext;
  logic             wb_q;
  logic             issue, pop, store_pop, ld_done, enq;
  logic [DEPTH-1:0] cmt_hit;
  logic [XLEN:0]    snp1 [DEPTH];
  logic [XLEN:0]    snp2 [DEPTH];
  logic [XLEN:0]    in_snp1, in_snp2;

  // Returns {hit, value}; scanning from the top lets the lowest-index bus win.
  function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] t);
    logic [XLEN:0] r;
    r = '0;
    for (int b = NUM_CDB - 1; b >= 0; b--)
      if (cdb_valid[b] && cdb_tag[b*TAG_W +: TAG_W] == t)
        r = {1'b1, cdb_val[b*XLEN +: XLEN]};
    return r;
  endfunction

  function automatic logic [XLEN-1:0] size_ext(input logic [XLEN-1:0] d,
                                               input logic [1:0] sz, input logic sx);
    case (sz)
      2'b00:   return {{(XLEN-8){sx & d[7]}}, d[7:0]};
      2'b01:   return {{(XLEN-16){sx & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign hd        = q[head];
  assign iss_ready = count < CW'(DEPTH);
  assign empty     = count == '0;
  assign enq       = iss_valid && iss_ready && !flush;
  assign ccount_n  = ccount + CW'(|cmt_hit) - CW'(store_pop);
  assign wb_valid  = wb_q && !(rdy && flush);
  assign fsm_state = state;

  always_comb begin
    cmt_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      snp1[i]    = snoop(q[i].rs1[TAG_W-1:0]);
      snp2[i]    = snoop(q[i].rs2[TAG_W-1:0]);
      cmt_hit[i] = cmt_valid && q[i].valid && q[i].store && !q[i].committed &&
                   q[i].tag == cmt_tag;
    end
  end

  always_comb begin
    in_snp1       = snoop(iss_rs1_val[TAG_W-1:0]);
    in_snp2       = snoop(iss_rs2_val[TAG_W-1:0]);
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.store   = iss_store;
    new_e.sext    = iss_sext;
    new_e.size    = iss_size;
    new_e.imm     = iss_imm;
    new_e.tag     = iss_tag;
    new_e.rs1     = iss_rs1_val;
    new_e.rs1_rdy = iss_rs1_rdy;
    new_e.rs2     = iss_rs2_val;
    new_e.rs2_rdy = iss_rs2_rdy || !iss_store;
    if (!iss_rs1_rdy && in_snp1[XLEN]) begin
      new_e.rs1     = in_snp1[XLEN-1:0];
      new_e.rs1_rdy = 1'b1;
    end
    if (iss_store && !iss_rs2_rdy && in_snp2[XLEN]) begin
      new_e.rs2     = in_snp2[XLEN-1:0];
      new_e.rs2_rdy = 1'b1;
    end
  end

  // A load flushed while in flight leaves the queue at once; DROP only absorbs its ack.
  always_comb begin
    state_n   = state;
    issue     = 1'b0;
    pop       = 1'b0;
    store_pop = 1'b0;
    ld_done   = 1'b0;
    case (state)
      IDLE: if (!flush && hd.valid && hd.rs1_rdy &&
                (!hd.store || (hd.rs2_rdy && hd.committed))) begin
        issue   = 1'b1;
        state_n = REQ;
      end
      REQ: if (mem_ack) begin
        pop       = 1'b1;
        store_pop = mem_we;
        ld_done   = !mem_we && !flush;
        state_n   = IDLE;
      end else if (flush && !mem_we) begin
        pop     = 1'b1;
        state_n = DROP;
      end
      DROP: if (mem_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (rdy) state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      ccount <= '0;
    end else if (rdy) begin
      head   <= head + PW'(pop);
      ccount <= ccount_n;
      if (flush) begin
        tail  <= head + PW'(pop) + ccount_n[PW-1:0];
        count <= ccount_n;
      end else begin
        tail  <= tail + PW'(enq);
        count <= count + CW'(enq) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid && !q[i].rs1_rdy && snp1[i][XLEN]) begin
          q[i].rs1     <= snp1[i][XLEN-1:0];
          q[i].rs1_rdy <= 1'b1;
        end
        if (q[i].valid && !q[i].rs2_rdy && snp2[i][XLEN]) begin
          q[i].rs2     <= snp2[i][XLEN-1:0];
          q[i].rs2_rdy <= 1'b1;
        end
        if (cmt_hit[i]) q[i].committed <= 1'b1;
        if (flush && !(q[i].committed || cmt_hit[i])) q[i].valid <= 1'b0;
      end
      if (pop) q[head] <= '0;
      if (enq) q[tail] <= new_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      req_tag   <= '0;
      req_sext  <= 1'b0;
      wb_q      <= 1'b0;
      wb_tag    <= '0;
      wb_data   <= '0;
    end else if (rdy) begin
      wb_q <= ld_done;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= hd.store;
        mem_addr  <= hd.rs1 + hd.imm;
        mem_wdata <= size_ext(hd.rs2, hd.size, 1'b0);
        mem_size  <= hd.size;
        req_tag   <= hd.tag;
        req_sext  <= hd.sext;
      end else if (mem_ack && state != IDLE) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (ld_done) begin
        wb_tag  <= req_tag;
        wb_data <= size_ext(mem_rdata, mem_size, req_sext);
      end
    end
  end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: hand-computed vectors, with a writeback scoreboard
// that matches every wb_valid pulse against an expected {tag, data} queue.
module tb_lsb_queue;
  localparam int DEPTH   = 16;
  localparam int TAG_W   = 4;
  localparam int XLEN    = 32;
  localparam int NUM_CDB = 2;
  localparam int EW      = TAG_W + XLEN;

  logic                     clk = 1'b0;
  logic                     rst, rdy;
  logic                     iss_valid, iss_ready, iss_store, iss_sext;
  logic [1:0]               iss_size;
  logic [XLEN-1:0]          iss_imm, iss_rs1_val, iss_rs2_val;
  logic                     iss_rs1_rdy, iss_rs2_rdy;
  logic [TAG_W-1:0]         iss_tag;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*XLEN-1:0]  cdb_val;
  logic                     cmt_valid;
  logic [TAG_W-1:0]         cmt_tag;
  logic                     flush;
  logic                     mem_req, mem_we, mem_ack;
  logic [XLEN-1:0]          mem_addr, mem_wdata, mem_rdata;
  logic [1:0]               mem_size;
  logic                     wb_valid;
  logic [TAG_W-1:0]         wb_tag;
  logic [XLEN-1:0]          wb_data;
  logic                     empty;
  logic [1:0]               fsm_state;

  logic [EW-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  lsb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_store(iss_store),
    .iss_size(iss_size), .iss_sext(iss_sext), .iss_imm(iss_imm),
    .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
    .iss_rs1_rdy(iss_rs1_rdy), .iss_rs2_rdy(iss_rs2_rdy), .iss_tag(iss_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .empty(empty), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset helpers ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rdy = 1'b1; iss_valid = 1'b0; iss_store = 1'b0; iss_size = 2'b00; iss_sext = 1'b0;
    iss_imm = '0; iss_rs1_val = '0; iss_rs2_val = '0; iss_rs1_rdy = 1'b0; iss_rs2_rdy = 1'b0;
    iss_tag = '0; cdb_valid = '0; cdb_tag = '0; cdb_val = '0; cmt_valid = 1'b0;
    cmt_tag = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic drive_op(input logic st, input logic [1:0] sz, input logic sx,
                          input logic [31:0] imm, input logic [31:0] rs1, input logic r1,
                          input logic [31:0] rs2, input logic r2, input logic [3:0] tg);
    iss_valid = 1'b1; iss_store = st; iss_size = sz; iss_sext = sx; iss_imm = imm;
    iss_rs1_val = rs1; iss_rs1_rdy = r1; iss_rs2_val = rs2; iss_rs2_rdy = r2; iss_tag = tg;
  endtask

  task automatic enq_op(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic r1,
                        input logic [31:0] rs2, input logic r2, input logic [3:0] tg);
    int n = 0;
    drive_op(st, sz, sx, imm, rs1, r1, rs2, r2, tg);
    while (!iss_ready && n < 200) begin tick(); n++; end
    if (!iss_ready) check_eq("enq_timeout", 32'(iss_ready), 32'd1);
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic cdb_pulse(input int bus, input logic [3:0] tg, input logic [31:0] val);
    cdb_valid[bus] = 1'b1;
    cdb_tag[bus*TAG_W +: TAG_W] = tg;
    cdb_val[bus*XLEN +: XLEN] = val;
    tick();
    cdb_valid = '0;
  endtask

  task automatic commit(input logic [3:0] tg);
    cmt_valid = 1'b1; cmt_tag = tg;
    tick();
    cmt_valid = 1'b0;
  endtask

  task automatic mem_serve(input logic [31:0] rdata, output logic we, output logic [31:0] addr,
                           output logic [31:0] wdata, output logic [1:0] sz, output logic ra);
    int n = 0;
    while (!mem_req && n < 200) begin tick(); n++; end
    check_eq("req_seen", 32'(mem_req), 32'd1);
    we = mem_we; addr = mem_addr; wdata = mem_wdata; sz = mem_size;
    mem_ack = 1'b1; mem_rdata = rdata;
    ra = iss_ready;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : wb_mon
    logic [EW-1:0] e;
    if (wb_valid) begin
      if (exp_q.size() == 0) check_eq("wb_unexpected", 32'(wb_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        check_eq("wb_tag", 32'(wb_tag), 32'(e[EW-1:XLEN]));
        check_eq("wb_data", wb_data, e[XLEN-1:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic we, ra;
    logic [31:0] addr, wdata;
    logic [1:0] sz;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_iss_ready", 32'(iss_ready), 32'd1);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_state", 32'(fsm_state), 32'd0);
    rst = 1'b0;
    tick();

    // LW rs1=0x100 imm=4, tag 3
    enq_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h100, 1'b1, 32'h0, 1'b0, 4'd3);
    check_eq("lw_req_latency", 32'(mem_req), 32'd0);
    tick();
    check_eq("lw_req", 32'(mem_req), 32'd1);
    exp_q.push_back({4'd3, 32'hDEADBEEF});
    mem_serve(32'hDEADBEEF, we, addr, wdata, sz, ra);
    check_eq("lw_addr", addr, 32'h104);
    check_eq("lw_size", 32'(sz), 32'd2);
    check_eq("lw_we", 32'(we), 32'd0);
    check_eq("lw_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("lw_wb_data", wb_data, 32'hDEADBEEF);

    // LB sext, LBU, LH sext
    enq_op(1'b0, 2'b00, 1'b1, 32'h0, 32'h10, 1'b1, 32'h0, 1'b0, 4'd1);
    enq_op(1'b0, 2'b00, 1'b0, 32'h0, 32'h11, 1'b1, 32'h0, 1'b0, 4'd2);
    enq_op(1'b0, 2'b01, 1'b1, 32'h0, 32'h12, 1'b1, 32'h0, 1'b0, 4'd4);
    exp_q.push_back({4'd1, 32'hFFFFFF80});
    exp_q.push_back({4'd2, 32'h00000080});
    exp_q.push_back({4'd4, 32'hFFFF8001});
    mem_serve(32'h00000080, we, addr, wdata, sz, ra);
    check_eq("lb_size", 32'(sz), 32'd0);
    mem_serve(32'h00000080, we, addr, wdata, sz, ra);
    check_eq("lbu_addr", addr, 32'h11);
    mem_serve(32'h00008001, we, addr, wdata, sz, ra);
    check_eq("lh_size", 32'(sz), 32'd1);
    repeat (2) tick();

    // SW waiting on tag 5, value arrives on bus 1, issues only after commit
    enq_op(1'b1, 2'b10, 1'b0, 32'h0, 32'h200, 1'b1, 32'h5, 1'b0, 4'd9);
    cdb_pulse(1, 4'd5, 32'h55);
    repeat (4) tick();
    check_eq("sw_wait_commit", 32'(mem_req), 32'd0);
    commit(4'd9);
    mem_serve(32'h0, we, addr, wdata, sz, ra);
    check_eq("sw_we", 32'(we), 32'd1);
    check_eq("sw_wdata", wdata, 32'h55);
    check_eq("sw_addr", addr, 32'h200);
    tick();
    check_eq("sw_empty", 32'(empty), 32'd1);

    // Fill with stalled head, then stream 3*DEPTH ops through for pointer wrap
    enq_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000000E, 1'b0, 32'h0, 1'b0, 4'd0);
    for (int i = 1; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check_eq("ready_before_full", 32'(iss_ready), 32'd1);
      enq_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h1000 + 32'(4 * i), 1'b1, 32'h0, 1'b0, 4'(i));
    end
    check_eq("ready_at_full", 32'(iss_ready), 32'd0);
    check_eq("stalled_head", 32'(mem_req), 32'd0);
    cdb_pulse(0, 4'hE, 32'h1000);
    for (int j = 0; j < 3 * DEPTH; j++) begin
      exp_q.push_back({4'(j), 32'hA0000000 + 32'(j)});
      mem_serve(32'hA0000000 + 32'(j), we, addr, wdata, sz, ra);
      check_eq("wrap_addr", addr, 32'h1000 + 32'(4 * j));
      if (j == 0) begin
        check_eq("ready_during_pop", 32'(ra), 32'd0);
        check_eq("ready_after_pop", 32'(iss_ready), 32'd1);
      end
      if (j + DEPTH < 3 * DEPTH)
        enq_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h1000 + 32'(4 * (j + DEPTH)), 1'b1,
               32'h0, 1'b0, 4'(j + DEPTH));
    end
    repeat (2) tick();
    check_eq("wrap_empty", 32'(empty), 32'd1);

    // Flush with a load in flight and two committed SB stores behind it
    enq_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h800, 1'b1, 32'h0, 1'b0, 4'd1);
    enq_op(1'b1, 2'b00, 1'b0, 32'h0, 32'h400, 1'b1, 32'h1AB, 1'b1, 4'd2);
    enq_op(1'b1, 2'b00, 1'b0, 32'h1, 32'h400, 1'b1, 32'h2CD, 1'b1, 4'd3);
    enq_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h804, 1'b1, 32'h0, 1'b0, 4'd4);
    enq_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h808, 1'b1, 32'h0, 1'b0, 4'd5);
    commit(4'd2);
    commit(4'd3);
    check_eq("fl_load_req", mem_addr, 32'h800);
    drive_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h900, 1'b1, 32'h0, 1'b0, 4'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0; iss_valid = 1'b0;
    check_eq("fl_state_drop", 32'(fsm_state), 32'd2);
    check_eq("fl_req_held", 32'(mem_req), 32'd1);
    mem_serve(32'h00000BAD, we, addr, wdata, sz, ra);
    mem_serve(32'h0, we, addr, wdata, sz, ra);
    check_eq("fl_sb1_addr", addr, 32'h400);
    check_eq("fl_sb1_wdata", wdata, 32'hAB);
    check_eq("fl_sb1_size", 32'(sz), 32'd0);
    mem_serve(32'h0, we, addr, wdata, sz, ra);
    check_eq("fl_sb2_addr", addr, 32'h401);
    check_eq("fl_sb2_wdata", wdata, 32'hCD);
    repeat (4) tick();
    check_eq("fl_no_more_req", 32'(mem_req), 32'd0);
    check_eq("fl_empty", 32'(empty), 32'd1);

    // Operand captured from bus 0 in the enqueue cycle
    drive_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h7, 1'b0, 32'h0, 1'b0, 4'd8);
    cdb_pulse(0, 4'd7, 32'h500);
    iss_valid = 1'b0;
    exp_q.push_back({4'd8, 32'h12345678});
    mem_serve(32'h12345678, we, addr, wdata, sz, ra);
    check_eq("cdb_same_cycle_addr", addr, 32'h510);

    // Duplicate tag on both buses: bus 0 wins
    enq_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h6, 1'b0, 32'h0, 1'b0, 4'd10);
    cdb_valid = 2'b11; cdb_tag = {4'd6, 4'd6}; cdb_val = {32'h700, 32'h600};
    tick();
    cdb_valid = '0;
    exp_q.push_back({4'd10, 32'h0000CAFE});
    mem_serve(32'h0000CAFE, we, addr, wdata, sz, ra);
    check_eq("cdb_priority_addr", addr, 32'h600);
    repeat (2) tick();

    // rdy=0 ignores an offered op
    rdy = 1'b0;
    drive_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h40, 1'b1, 32'h0, 1'b0, 4'd11);
    repeat (2) tick();
    check_eq("freeze_empty", 32'(empty), 32'd1);
    iss_valid = 1'b0;
    rdy = 1'b1;
    repeat (2) tick();
    check_eq("freeze_no_req", 32'(mem_req), 32'd0);

    check_eq("wb_missing", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
